// File: rtl/fire_detector.sv
// Fire sensor front end: smoke synchroniser, temperature hysteresis, confirm/hold FSM.
// Optional sample watchdog (fail-safe alarm on missing samples) when FIRE_WATCHDOG_EN is defined.
module fire_detector #(
  parameter int TEMP_W         = 8,
  parameter int TEMP_THRESH    = 60,
  parameter int HYST           = 4,
  parameter int CONFIRM_CYCLES = 16,
  parameter int HOLD_CYCLES    = 64,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              smoke_raw,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] temp_raw,
  input  logic              clear,
  output logic              fire_sensor,
  output logic [1:0]        state,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_FIRE    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam int CNT_MAX = (CONFIRM_CYCLES > HOLD_CYCLES) ? CONFIRM_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_CONF = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TEMP_W-1:0] T_HI     = TEMP_W'(TEMP_THRESH);
  localparam logic [TEMP_W-1:0] T_LO     = TEMP_W'(TEMP_THRESH - HYST);

  if (CONFIRM_CYCLES < 1 || HOLD_CYCLES < 1 || HYST > TEMP_THRESH || WDOG_CYCLES < 1) begin : g_bad_param
    $error("fire_detector: illegal parameter combination");
  end

  logic             r_smoke_meta;
  logic             r_smoke_s;
  logic             r_temp_hot;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fire;
  logic             r_fault;
  logic             w_temp_over;
  logic             w_haz;
  logic             w_wdog_trip;
  logic             w_fire_nxt;
  logic             w_fault_nxt;

  assign w_temp_over = r_temp_hot ? (temp_raw >= T_LO) : (temp_raw >= T_HI);
  assign w_haz       = sample_valid & (r_smoke_s | w_temp_over);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_smoke_meta <= 1'b0;
      r_smoke_s    <= 1'b0;
      r_temp_hot   <= 1'b0;
    end else begin
      r_smoke_meta <= smoke_raw;
      r_smoke_s    <= r_smoke_meta;
      if (sample_valid) begin
        if (temp_raw >= T_HI)     r_temp_hot <= 1'b1;
        else if (temp_raw < T_LO) r_temp_hot <= 1'b0;
      end
    end
  end

`ifdef FIRE_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_nxt;

  always_comb begin
    w_wdog_nxt = r_wdog;
    if (clear || sample_valid)  w_wdog_nxt = '0;
    else if (r_wdog != WDOG_MAX) w_wdog_nxt = r_wdog + WDOG_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wdog <= '0;
    else          r_wdog <= w_wdog_nxt;
  end

  // Trip stays asserted for as long as the counter sits at its saturated value.
  assign w_wdog_trip = (w_wdog_nxt == WDOG_MAX);
`else
  assign w_wdog_trip = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_haz) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = (CONFIRM_CYCLES == 1) ? S_FIRE : S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (w_haz) begin
            if (r_cnt >= CNT_CONF - CNT_ONE) begin
              w_cnt_nxt   = CNT_CONF;
              w_state_nxt = S_FIRE;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else if (sample_valid) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_FIRE: begin
          if (sample_valid && !w_haz) begin
            w_cnt_nxt   = CNT_HOLD;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          // A hazard wins even on the cycle the hold count expires.
          w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CNT_ONE;
          if (w_haz)              w_state_nxt = S_FIRE;
          else if (r_cnt <= CNT_ONE) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_fire_nxt  = (w_state_nxt == S_FIRE) || (w_state_nxt == S_HOLD) || w_wdog_trip;
  assign w_fault_nxt = clear ? 1'b0
                             : (r_fault | (sample_valid & (&temp_raw)) | w_wdog_trip);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fire  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fire  <= w_fire_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign fire_sensor = r_fire;
  assign state       = r_state;
  assign fault       = r_fault;

endmodule
